// File: rtl/intc_prio_pkg.sv
// Shared types for the priority interrupt controller: FSM states, winner record
// and the bus-index width helper.
package intc_prio_pkg;

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  // Widest bus/channel index the controller supports (8 buses, 32 channels)
  localparam int BUS_MAXW = 3;
  localparam int ID_MAXW  = 5;

  typedef struct packed {
    logic [BUS_MAXW-1:0] bus;
    logic [ID_MAXW-1:0]  id;
    logic                hit;
  } winner_t;

  function automatic int calc_bw(input int nbus);
    return (nbus <= 1) ? 1 : $clog2(nbus);
  endfunction

endpackage

// File: rtl/prio_first.sv
// Lowest-index-first finder: reports whether any bit of vec is set and the
// index of the lowest set bit (index is 0 when nothing is set).
module prio_first #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Scan downwards so the lowest set bit is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/intc_prio.sv
// Registered priority interrupt controller: sticky pending bits per bus/channel,
// rank arbitration (bus, then channel) and a valid/ack presentation handshake.
module intc_prio
  import intc_prio_pkg::*;
#(
  parameter int NCH  = 9,
  parameter int NBUS = 3,
  parameter int IDW  = $clog2(NCH),
  parameter int BW   = calc_bw(NBUS)
) (
  input  logic                CK,
  input  logic                RN,
  input  logic [NBUS*NCH-1:0] REQ,
  input  logic [NCH-1:0]      EN,
  input  logic                IRQ_ACK,
  input  logic                OVF_CLR,
  output logic                IRQ_VLD,
  output logic [BW-1:0]       IRQ_BUS,
  output logic [IDW-1:0]      IRQ_ID,
  output logic [NBUS-1:0]     ANY_PEND,
  output logic [NBUS-1:0]     OVF
);

  state_t              state, state_nxt;
  logic                load;
  logic [NBUS*NCH-1:0] pend, cand, set_m, clr_m;
  logic [NBUS-1:0]     bus_hit, ovf_new;
  logic [IDW-1:0]      ch_idx [NBUS];
  logic                top_hit;
  logic [BW-1:0]       bsel;
  logic [IDW-1:0]      sel_id;
  logic                ack;
  winner_t             win;

  assign cand  = pend & {NBUS{EN}};
  assign set_m = REQ & {NBUS{EN}};
  assign ack   = (state == ST_PRESENT) && IRQ_ACK;

  for (genvar b = 0; b < NBUS; b++) begin : g_bus
    prio_first #(.W(NCH), .IW(IDW)) u_ch (
      .vec (cand[b*NCH +: NCH]),
      .hit (bus_hit[b]),
      .idx (ch_idx[b])
    );
  end

  prio_first #(.W(NBUS), .IW(BW)) u_bus (
    .vec (bus_hit),
    .hit (top_hit),
    .idx (bsel)
  );

  always_comb begin
    sel_id = '0;
    for (int b = 0; b < NBUS; b++) begin
      if (bsel == BW'(b)) sel_id = ch_idx[b];
    end
    win.hit = top_hit;
    win.bus = BUS_MAXW'(bsel);
    win.id  = ID_MAXW'(sel_id);
  end

  // Only the low BW/IDW bits of the zero-extended winner reach the outputs
  logic unused_win;
  assign unused_win = ^{win.bus, win.id};

  // The acked bit is cleared unless a fresh request lands on it in the same edge
  always_comb begin
    clr_m   = '0;
    ovf_new = '0;
    for (int b = 0; b < NBUS; b++) begin
      for (int c = 0; c < NCH; c++) begin
        clr_m[b*NCH+c] = ack && (IRQ_BUS == BW'(b)) && (IRQ_ID == IDW'(c));
        if (set_m[b*NCH+c] && pend[b*NCH+c] && !clr_m[b*NCH+c]) ovf_new[b] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win.hit) begin
          state_nxt = ST_PRESENT;
          load      = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (IRQ_ACK) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state    <= ST_IDLE;
      pend     <= '0;
      OVF      <= '0;
      ANY_PEND <= '0;
      IRQ_BUS  <= '0;
      IRQ_ID   <= '0;
    end else begin
      state    <= state_nxt;
      pend     <= (pend & ~clr_m) | set_m;
      OVF      <= (OVF & {NBUS{~OVF_CLR}}) | ovf_new;
      ANY_PEND <= bus_hit;
      if (load) begin
        IRQ_BUS <= win.bus[BW-1:0];
        IRQ_ID  <= win.id[IDW-1:0];
      end
    end
  end

  assign IRQ_VLD = (state == ST_PRESENT);

endmodule

// File: tb/tb_intc_prio.sv
// Bench for intc_prio: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a behavioural model.
module tb_intc_prio;

  localparam int NCH  = 9;
  localparam int NBUS = 3;

  logic                CK = 1'b0;
  logic                RN = 1'b0;
  logic [NBUS*NCH-1:0] REQ = '0;
  logic [NCH-1:0]      EN = '1;
  logic                IRQ_ACK = 1'b0;
  logic                OVF_CLR = 1'b0;
  logic                IRQ_VLD;
  logic [1:0]          IRQ_BUS;
  logic [3:0]          IRQ_ID;
  logic [NBUS-1:0]     ANY_PEND;
  logic [NBUS-1:0]     OVF;

  int errors = 0;
  int checks = 0;

  intc_prio #(.NCH(NCH), .NBUS(NBUS)) dut (
    .CK       (CK),
    .RN       (RN),
    .REQ      (REQ),
    .EN       (EN),
    .IRQ_ACK  (IRQ_ACK),
    .OVF_CLR  (OVF_CLR),
    .IRQ_VLD  (IRQ_VLD),
    .IRQ_BUS  (IRQ_BUS),
    .IRQ_ID   (IRQ_ID),
    .ANY_PEND (ANY_PEND),
    .OVF      (OVF)
  );

  always #5 CK = ~CK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending matrix, overflow flags and presented interrupt
  bit m_pend [NBUS][NCH];
  bit m_ovf  [NBUS];
  bit m_anyp [NBUS];
  bit m_vld;
  int m_bus, m_id;

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      foreach (m_pend[b, c]) m_pend[b][c] = 0;
      foreach (m_ovf[b]) begin m_ovf[b] = 0; m_anyp[b] = 0; end
      m_vld = 0; m_bus = 0; m_id = 0;
    end else begin
      bit found, ack_now, req_bit, clr_bit;
      bit novf [NBUS];
      int wb, wc;
      found = 0; wb = 0; wc = 0;
      ack_now = m_vld && IRQ_ACK;
      for (int b = 0; b < NBUS; b++) begin
        m_anyp[b] = 0;
        novf[b] = 0;
        for (int c = 0; c < NCH; c++) begin
          if (m_pend[b][c] && EN[c]) begin
            m_anyp[b] = 1;
            if (!found) begin found = 1; wb = b; wc = c; end
          end
        end
      end
      for (int b = 0; b < NBUS; b++) begin
        for (int c = 0; c < NCH; c++) begin
          req_bit = REQ[b*NCH+c] && EN[c];
          clr_bit = ack_now && (b == m_bus) && (c == m_id);
          if (req_bit && m_pend[b][c] && !clr_bit) novf[b] = 1;
          if (req_bit) m_pend[b][c] = 1;
          else if (clr_bit) m_pend[b][c] = 0;
        end
        m_ovf[b] = (m_ovf[b] && !OVF_CLR) || novf[b];
      end
      if (m_vld) begin
        if (IRQ_ACK) m_vld = 0;
      end else if (found) begin
        m_vld = 1; m_bus = wb; m_id = wc;
      end
    end
  end

  function automatic int pack3(input bit v [NBUS]);
    int r = 0;
    for (int b = 0; b < NBUS; b++) if (v[b]) r |= (1 << b);
    return r;
  endfunction

  always @(negedge CK) begin
    if (RN) begin
      chk("model_vld", int'(IRQ_VLD), int'(m_vld));
      chk("model_any_pend", int'(ANY_PEND), pack3(m_anyp));
      chk("model_ovf", int'(OVF), pack3(m_ovf));
      if (m_vld) begin
        chk("model_bus", int'(IRQ_BUS), m_bus);
        chk("model_id", int'(IRQ_ID), m_id);
      end
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk_pres(input string nm, input int b, input int c);
    chk({nm, "_vld"}, int'(IRQ_VLD), 1);
    chk({nm, "_bus"}, int'(IRQ_BUS), b);
    chk({nm, "_id"}, int'(IRQ_ID), c);
  endtask

  task automatic do_reset();
    RN = 1'b0; REQ = '0; EN = '1; IRQ_ACK = 1'b0; OVF_CLR = 1'b0;
    #12;
    RN = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();
    chk("rst_vld", int'(IRQ_VLD), 0);
    chk("rst_any", int'(ANY_PEND), 0);
    chk("rst_ovf", int'(OVF), 0);

    // Single request bus1 ch4
    REQ[1*NCH+4] = 1'b1; tick(); REQ = '0;
    chk("t1_gap_vld", int'(IRQ_VLD), 0);
    tick();
    chk_pres("t1", 1, 4);
    chk("t1_any", int'(ANY_PEND), 3'b010);
    IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
    chk("t1_ack_vld", int'(IRQ_VLD), 0);
    tick();
    chk("t1_any_after", int'(ANY_PEND), 0);

    // Three simultaneous requests, ack held high
    REQ[2*NCH+0] = 1'b1; REQ[0*NCH+8] = 1'b1; REQ[0*NCH+3] = 1'b1;
    tick(); REQ = '0; IRQ_ACK = 1'b1;
    tick(); chk_pres("t2a", 0, 3);
    tick(); chk("t2a_gap", int'(IRQ_VLD), 0);
    tick(); chk_pres("t2b", 0, 8);
    tick(); chk("t2b_gap", int'(IRQ_VLD), 0);
    tick(); chk_pres("t2c", 2, 0);
    tick(); IRQ_ACK = 1'b0;
    chk("t2_done", int'(IRQ_VLD), 0);

    // Disabled channel never pends
    EN[5] = 1'b0; REQ[5] = 1'b1; tick(); REQ = '0;
    tick(); tick();
    chk("t3_vld", int'(IRQ_VLD), 0);
    chk("t3_any", int'(ANY_PEND), 0);
    EN = '1; tick(); tick();
    chk("t3_en_vld", int'(IRQ_VLD), 0);
    chk("t3_en_any", int'(ANY_PEND), 0);

    // Overflow and set/clear collision on (1,2)
    REQ[1*NCH+2] = 1'b1; tick(); REQ = '0;
    tick(); chk_pres("t4", 1, 2);
    REQ[1*NCH+2] = 1'b1; tick(); REQ = '0;
    chk("t4_ovf", int'(OVF), 3'b010);
    IRQ_ACK = 1'b1; REQ[1*NCH+2] = 1'b1; tick(); IRQ_ACK = 1'b0; REQ = '0;
    chk("t4_coll_ovf", int'(OVF), 3'b010);
    tick(); chk_pres("t4_re", 1, 2);
    chk("t4_re_ovf", int'(OVF), 3'b010);
    IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
    OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
    chk("t4_clr", int'(OVF), 0);

    // No retraction by a higher-rank request
    REQ[1] = 1'b1; tick(); REQ = '0;
    tick(); chk_pres("t5a", 0, 1);
    REQ[0] = 1'b1; tick(); REQ = '0;
    tick(); chk_pres("t5hold", 0, 1);
    IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
    tick(); chk_pres("t5b", 0, 0);
    IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;

    // Asynchronous reset mid-handshake
    REQ[0] = 1'b1; REQ[NCH+3] = 1'b1; REQ[2*NCH+7] = 1'b1; tick(); REQ = '0;
    tick(); chk("t6_vld_pre", int'(IRQ_VLD), 1);
    #2 RN = 1'b0;
    #1;
    chk("t6_vld", int'(IRQ_VLD), 0);
    chk("t6_bus", int'(IRQ_BUS), 0);
    chk("t6_id", int'(IRQ_ID), 0);
    chk("t6_any", int'(ANY_PEND), 0);
    chk("t6_ovf", int'(OVF), 0);
    #9 RN = 1'b1;
    tick(); tick(); tick();
    chk("t6_post_vld", int'(IRQ_VLD), 0);
    chk("t6_post_any", int'(ANY_PEND), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      REQ     = (NBUS*NCH)'($urandom & $urandom & $urandom);
      EN      = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
      IRQ_ACK = ($urandom_range(0, 2) != 0);
      OVF_CLR = ($urandom_range(0, 15) == 0);
      tick();
    end
    REQ = '0; IRQ_ACK = 1'b0; OVF_CLR = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
